// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Parametrised VGA timing generator and test-pattern source. Free-running
//   horizontal and vertical counters produce sync/blank timing. The pattern
//   mode, the frame counter and an animated ramp offset only update at the
//   frame boundary, so a frame never changes pattern or offset partway through.
//   Every output is registered once, which keeps syncs, blanks and RGB
//   aligned with each other.
//
// Ports
//   clk      in   pixel clock
//   reset    in   synchronous, active-high reset
//   ui_in    in   [2:0] pattern select, [3] invert, [7:4] ramp step per frame
//   hsync    out  horizontal sync, active level HSYNC_POL
//   vsync    out  vertical sync, active level VSYNC_POL
//   hblank   out  high when hpos >= H_VIS
//   vblank   out  high when vpos >= V_VIS
//   visible  out  !hblank && !vblank
//   r, g, b  out  pixel colour, COLOR_BITS per channel
//   o_mode   out  mode latched at the last frame boundary
//   o_hpos   out  horizontal position
//   o_vpos   out  vertical position
//   o_frame  out  frame counter
module vga_pattern_gen #(
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COLOR_BITS = 8,
  parameter int CHK_SHIFT  = 4,
  parameter int FRAME_BITS = 8,
  localparam int H_TOTAL   = H_VIS + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_VIS + V_FP + V_SYNC + V_BP,
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL),
  localparam int CB        = COLOR_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            ui_in,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  hblank,
  output logic                  vblank,
  output logic                  visible,
  output logic [CB-1:0]         r,
  output logic [CB-1:0]         g,
  output logic [CB-1:0]         b,
  output logic [7:0]            o_mode,
  output logic [HW-1:0]         o_hpos,
  output logic [VW-1:0]         o_vpos,
  output logic [FRAME_BITS-1:0] o_frame
);

  localparam logic [HW-1:0] H_MAX    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_MAX    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_W  = HW'(H_VIS);
  localparam logic [VW-1:0] V_VIS_W  = VW'(V_VIS);
  localparam logic [HW-1:0] H_LAST   = HW'(H_VIS - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_VIS - 1);
  localparam logic [HW-1:0] HS_START = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [HW+3:0] BAR_DIV  = (HW+4)'(H_VIS);
  localparam logic [CB-1:0] GREY     = CB'(1) << (CB - 1);

  logic [HW-1:0]         h;
  logic [VW-1:0]         v;
  logic [FRAME_BITS-1:0] frame;
  logic [CB-1:0]         ofs;
  logic [7:0]            mode;
  logic                  h_last;
  logic                  frame_end;
  logic [CB-1:0]         step;

  assign h_last    = (h == H_MAX);
  assign frame_end = h_last && (v == V_MAX);
  assign step      = CB'(ui_in[7:4]);

  // Raster counters plus the per-frame state. Mode, frame count and ramp
  // offset all move together on the last pixel of the frame, and the offset
  // uses the step from the same ui_in sample that becomes the new mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      h     <= '0;
      v     <= '0;
      frame <= '0;
      ofs   <= '0;
      mode  <= '0;
    end else begin
      if (h_last) begin
        h <= '0;
        if (v == V_MAX) v <= '0;
        else            v <= v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      if (frame_end) begin
        frame <= frame + 1'b1;
        mode  <= ui_in;
        ofs   <= ofs + step;
      end
    end
  end

  logic          hs_act;
  logic          vs_act;
  logic          hb;
  logic          vb;
  logic          vis;
  logic [CB-1:0] x_cb;
  logic [CB-1:0] y_cb;
  logic [HW+3:0] bar_prod;
  logic [2:0]    bar;
  logic          chk;
  logic          border;
  logic [CB-1:0] pr;
  logic [CB-1:0] pg;
  logic [CB-1:0] pb;

  // Pixel colour for the current counter position. The bar index is x*8/H_VIS
  // and is only meaningful inside the visible area, where it stays below 8.
  always_comb begin
    hs_act   = (h >= HS_START) && (h < HS_END);
    vs_act   = (v >= VS_START) && (v < VS_END);
    hb       = (h >= H_VIS_W);
    vb       = (v >= V_VIS_W);
    vis      = !hb && !vb;
    x_cb     = CB'(h);
    y_cb     = CB'(v);
    bar_prod = {1'b0, h, 3'b000};
    bar      = 3'(bar_prod / BAR_DIV);
    chk      = h[CHK_SHIFT] ^ v[CHK_SHIFT];
    border   = (h == '0) || (h == H_LAST) || (v == '0) || (v == V_LAST);
    pr       = '0;
    pg       = '0;
    pb       = '0;
    case (mode[2:0])
      3'd0: begin pr = x_cb + ofs; pg = x_cb + ofs; pb = x_cb + ofs; end
      3'd1: begin pr = y_cb + ofs; pg = y_cb + ofs; pb = y_cb + ofs; end
      3'd2: begin pr = {CB{bar[2]}}; pg = {CB{bar[1]}}; pb = {CB{bar[0]}}; end
      3'd3: begin pr = {CB{chk}}; pg = {CB{chk}}; pb = {CB{chk}}; end
      3'd4: begin pr = x_cb; pg = y_cb; pb = ofs; end
      3'd5: begin pr = {CB{border}}; pg = {CB{border}}; pb = {CB{border}}; end
      3'd6: begin pr = '1; pg = '1; pb = '1; end
      3'd7: begin pr = GREY; pg = GREY; pb = GREY; end
    endcase
    if (mode[3]) begin
      pr = ~pr;
      pg = ~pg;
      pb = ~pb;
    end
    if (!vis) begin
      pr = '0;
      pg = '0;
      pb = '0;
    end
  end

  // Single output register stage; everything seen here describes the
  // counter/mode state of the previous cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync   <= ~HSYNC_POL;
      vsync   <= ~VSYNC_POL;
      hblank  <= 1'b0;
      vblank  <= 1'b0;
      visible <= 1'b0;
      r       <= '0;
      g       <= '0;
      b       <= '0;
      o_mode  <= '0;
      o_hpos  <= '0;
      o_vpos  <= '0;
      o_frame <= '0;
    end else begin
      hsync   <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync   <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      hblank  <= hb;
      vblank  <= vb;
      visible <= vis;
      r       <= pr;
      g       <= pg;
      b       <= pb;
      o_mode  <= mode;
      o_hpos  <= h;
      o_vpos  <= v;
      o_frame <= frame;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen, built with a reduced raster (24 x 13 clocks)
// so that many frames fit in a short run. A scoreboard model predicts every
// output on every clock; a vector table and several hand sequences check
// specific pixels and timing points against hand-derived constants.
module tb_vga_pattern_gen;

  localparam int H_VIS = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_VIS = 8,  V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CLKS = H_TOTAL * V_TOTAL;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int FW = 4;
  localparam int CS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    ui_in = 8'h00;
  logic          hsync, vsync, hblank, vblank, visible;
  logic [7:0]    r, g, b;
  logic [7:0]    o_mode;
  logic [HW-1:0] o_hpos;
  logic [VW-1:0] o_vpos;
  logic [FW-1:0] o_frame;

  vga_pattern_gen #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .COLOR_BITS(8), .CHK_SHIFT(CS), .FRAME_BITS(FW)
  ) dut (
    .clk(clk), .reset(reset), .ui_in(ui_in),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .visible(visible), .r(r), .g(g), .b(b),
    .o_mode(o_mode), .o_hpos(o_hpos), .o_vpos(o_vpos), .o_frame(o_frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          hblank;
    logic          vblank;
    logic          visible;
    logic [23:0]   rgb;
    logic [7:0]    mode;
    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic [FW-1:0] frame;
  } snap_t;

  typedef struct {
    logic [7:0]  ui;
    int          x;
    int          y;
    logic [23:0] rgb;
  } vec_t;

  snap_t      sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         mh = 0, mv = 0, mframe = 0, mofs = 0;
  logic [7:0] mmode = 8'h00;

  // Reference colour for pixel (x,y) under mode md and ramp offset ofs.
  function automatic logic [23:0] modelRgb(int x, int y, logic [7:0] md, int ofs);
    int p;
    int idx;
    logic [23:0] c;
    if (x >= H_VIS || y >= V_VIS) return 24'h000000;
    c = 24'h000000;
    case (md[2:0])
      3'd0: begin p = (x + ofs) % 256; c = {p[7:0], p[7:0], p[7:0]}; end
      3'd1: begin p = (y + ofs) % 256; c = {p[7:0], p[7:0], p[7:0]}; end
      3'd2: begin
        idx = x * 8 / H_VIS;
        c = {idx[2] ? 8'hFF : 8'h00, idx[1] ? 8'hFF : 8'h00, idx[0] ? 8'hFF : 8'h00};
      end
      3'd3: c = ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      3'd4: c = {x[7:0], y[7:0], ofs[7:0]};
      3'd5: c = (x == 0 || x == H_VIS - 1 || y == 0 || y == V_VIS - 1) ? 24'hFFFFFF : 24'h000000;
      3'd6: c = 24'hFFFFFF;
      3'd7: c = 24'h808080;
    endcase
    if (md[3]) c = ~c;
    return c;
  endfunction

  task automatic applyStimulus(input logic [7:0] ui, input logic rst);
    ui_in = ui;
    reset = rst;
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    snap_t e;
    snap_t a;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard empty at cycle %0d", cyc);
      return;
    end
    e = sbq.pop_front();
    a = {hsync, vsync, hblank, vblank, visible, r, g, b, o_mode, o_hpos, o_vpos, o_frame};
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL scoreboard cycle %0d got %h expected %h", cyc, a, e);
    end
  endtask

  // One clock: predict the outputs for this edge from the model state, then
  // advance the model, then compare the DUT just after the edge.
  task automatic stepCycle();
    snap_t e;
    @(posedge clk);
    cyc++;
    e = '0;
    if (reset) begin
      e.hsync = 1'b1;
      e.vsync = 1'b1;
      mh = 0; mv = 0; mframe = 0; mofs = 0; mmode = 8'h00;
    end else begin
      e.hsync   = !(mh >= H_VIS + H_FP && mh < H_VIS + H_FP + H_SYNC);
      e.vsync   = !(mv >= V_VIS + V_FP && mv < V_VIS + V_FP + V_SYNC);
      e.hblank  = (mh >= H_VIS);
      e.vblank  = (mv >= V_VIS);
      e.visible = (mh < H_VIS) && (mv < V_VIS);
      e.rgb     = modelRgb(mh, mv, mmode, mofs);
      e.mode    = mmode;
      e.hpos    = HW'(mh);
      e.vpos    = VW'(mv);
      e.frame   = FW'(mframe);
      if (mh == H_TOTAL - 1 && mv == V_TOTAL - 1) begin
        mframe = (mframe + 1) % (1 << FW);
        mmode  = ui_in;
        mofs   = (mofs + int'(ui_in[7:4])) % 256;
      end
      mh++;
      if (mh == H_TOTAL) begin
        mh = 0;
        mv++;
        if (mv == V_TOTAL) mv = 0;
      end
    end
    sbq.push_back(e);
    #1;
    checkOutput();
  endtask

  task automatic waitFrameChange();
    logic [FW-1:0] start;
    start = o_frame;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      stepCycle();
      if (o_frame !== start) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL frame_change timeout got %0d expected change", o_frame);
  endtask

  task automatic waitPixel(input int x, input int y);
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      if (o_hpos == HW'(x) && o_vpos == VW'(y)) return;
      stepCycle();
    end
    checks++;
    errors++;
    $display("[TB] FAIL pixel_search timeout got (%0d,%0d) expected (%0d,%0d)", o_hpos, o_vpos, x, y);
  endtask

  vec_t vecs[$];
  int   cnt, w, fall1, f0, vlow;
  logic mode_moved;
  logic [7:0] cur_ui;

  initial begin
    vecs = '{
      '{8'h02, 1, 0, 24'h000000}, '{8'h02, 2, 0, 24'h0000FF},
      '{8'h02, 12, 3, 24'hFFFF00}, '{8'h02, 15, 7, 24'hFFFFFF},
      '{8'h02, 17, 2, 24'h000000},
      '{8'h06, 5, 5, 24'hFFFFFF},
      '{8'h07, 0, 0, 24'h808080},
      '{8'h0B, 0, 0, 24'hFFFFFF}, '{8'h0B, 4, 0, 24'h000000},
      '{8'h0B, 4, 4, 24'hFFFFFF},
      '{8'h05, 3, 0, 24'hFFFFFF}, '{8'h05, 0, 3, 24'hFFFFFF},
      '{8'h05, 3, 3, 24'h000000}, '{8'h05, 15, 4, 24'hFFFFFF},
      '{8'h05, 3, 7, 24'hFFFFFF},
      '{8'h04, 5, 3, 24'h050300},
      '{8'h0C, 5, 3, 24'hFAFCFF},
      '{8'h0E, 2, 2, 24'h000000}, '{8'h0E, 20, 2, 24'h000000},
      '{8'h0E, 3, 9, 24'h000000},
      '{8'h30, 3, 0, 24'h060606}
    };

    // Reset and bring-up timing
    applyStimulus(8'h00, 1'b1);
    repeat (3) stepCycle();
    checkValue("reset_hsync", 32'(hsync), 1);
    checkValue("reset_vsync", 32'(vsync), 1);
    checkValue("reset_visible", 32'(visible), 0);
    checkValue("reset_rgb", {8'h00, r, g, b}, 0);
    applyStimulus(8'h00, 1'b0);
    stepCycle();
    checkValue("first_visible", 32'(visible), 1);
    checkValue("first_rgb", {8'h00, r, g, b}, 0);
    cnt = 1;
    while (hsync !== 1'b0 && cnt < 100) begin
      stepCycle();
      cnt++;
    end
    checkValue("hsync_fall_delay", cnt, H_VIS + H_FP + 1);
    fall1 = cyc;
    w = 0;
    while (hsync === 1'b0 && w < 100) begin
      w++;
      stepCycle();
    end
    checkValue("hsync_width", w, H_SYNC);
    while (hsync !== 1'b0 && (cyc - fall1) < 100) stepCycle();
    checkValue("hsync_period", cyc - fall1, H_TOTAL);

    // Frame timing over two frame boundaries
    waitFrameChange();
    checkValue("frame_1", 32'(o_frame), 1);
    f0 = cyc;
    vlow = 0;
    while (o_frame == 1 && (cyc - f0) < 2 * FRAME_CLKS) begin
      stepCycle();
      if (vsync === 1'b0) begin
        if (vlow == 0) begin
          checkValue("vsync_start_line", 32'(o_vpos), V_VIS + V_FP);
          checkValue("vsync_start_px", 32'(o_hpos), 0);
        end
        vlow++;
      end
    end
    checkValue("frame_2", 32'(o_frame), 2);
    checkValue("frame_period", cyc - f0, FRAME_CLKS);
    checkValue("vsync_low_clks", vlow, V_SYNC * H_TOTAL);

    // Mode changes mid-frame only take effect at the boundary
    repeat (50) stepCycle();
    applyStimulus(8'h06, 1'b0);
    mode_moved = 1'b0;
    f0 = cyc;
    while (o_frame == 2 && (cyc - f0) < 2 * FRAME_CLKS) begin
      if (o_mode !== 8'h00) mode_moved = 1'b1;
      stepCycle();
    end
    checkValue("mode_held", 32'(mode_moved), 0);
    checkValue("mode_latched", 32'(o_mode), 32'h06);
    cur_ui = 8'h06;

    // Pixel vector table
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].ui != cur_ui) begin
        applyStimulus(vecs[i].ui, 1'b0);
        cur_ui = vecs[i].ui;
        waitFrameChange();
      end
      waitPixel(vecs[i].x, vecs[i].y);
      checkValue($sformatf("vec%0d_rgb", i), {8'h00, r, g, b}, {8'h00, vecs[i].rgb});
    end

    // Ramp animation, offset wrap and frame counter wrap
    applyStimulus(8'hF0, 1'b1);
    repeat (3) stepCycle();
    applyStimulus(8'hF0, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      waitFrameChange();
      checkValue($sformatf("ramp_frame%0d", k), 32'(o_frame), k % 16);
      waitPixel(3, 0);
      checkValue($sformatf("ramp_px%0d", k), {8'h00, r, g, b}, ((3 + 15 * k) % 256) * 32'h010101);
    end

    // Reset asserted partway through a frame
    waitPixel(9, 5);
    applyStimulus(8'hF0, 1'b1);
    stepCycle();
    checkValue("midrst_mode", 32'(o_mode), 0);
    checkValue("midrst_hsync", 32'(hsync), 1);
    checkValue("midrst_visible", 32'(visible), 0);
    checkValue("midrst_hpos", 32'(o_hpos), 0);
    applyStimulus(8'hF0, 1'b0);
    stepCycle();
    checkValue("restart_hpos", 32'(o_hpos), 0);
    checkValue("restart_vpos", 32'(o_vpos), 0);
    checkValue("restart_visible", 32'(visible), 1);
    checkValue("restart_frame", 32'(o_frame), 0);
    stepCycle();
    checkValue("restart_hpos_next", 32'(o_hpos), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised successor to the fixed-mode VGA controller: generic H/V timing, colour depth, sync polarity and checker size.
- Adds a frame-synchronous mode latch, an animated ramp offset accumulator and eight test patterns.
- Sits between the `ui_in` pins and the RGB/sync pads; its debug outputs (mode, positions, frame count) are exported for the SPICE/gate-level wrapper.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch, clocks
- H_SYNC, 96, hsync width, clocks
- H_BP, 48, horizontal back porch, clocks
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vsync width, lines
- V_BP, 33, vertical back porch, lines
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- COLOR_BITS, 8, bits per colour channel (CB)
- CHK_SHIFT, 4, checker square = 2^CHK_SHIFT pixels
- FRAME_BITS, 8, frame counter width

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- ui_in  in  8  [2:0] pattern, [3] invert, [7:4] ramp step per frame
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- hblank  out  1  high when hpos >= H_VIS
- vblank  out  1  high when vpos >= V_VIS
- visible  out  1  !hblank && !vblank
- r, g, b  out  CB each  pixel colour
- o_mode  out  8  latched ui_in
- o_hpos  out  HW  HW = clog2(H_VIS+H_FP+H_SYNC+H_BP)
- o_vpos  out  VW  VW = clog2(V_TOTAL)
- o_frame  out  FRAME_BITS  frame counter

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `reset`; it is sampled only on rising `clk`.
- Totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters h and v:
  - h increments every clk and wraps H_TOTAL-1 -> 0.
  - v increments when h wraps, and wraps V_TOTAL-1 -> 0.
- Frame boundary (FB) = cycle with h == H_TOTAL-1 and v == V_TOTAL-1. At FB, all updates take effect together for the next frame:
  - frame <= frame+1, wrapping at 2^FRAME_BITS;
  - mode <= ui_in;
  - ramp offset ofs <= ofs + ui_in[7:4], truncated to CB bits, using the new step.
- ui_in changes mid-frame have no effect until the next FB.
- Output pipeline: one register stage.
  - Every output at cycle N+1 reflects counter/mode state at cycle N.
  - Syncs, blanks and RGB are therefore mutually aligned.
- hsync active while H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC.
- vsync active while V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC.
- Patterns, selected by mode[2:0] while visible; x = h, y = v:
  - 0: horizontal ramp, r=g=b = x[CB-1:0] + ofs
  - 1: vertical ramp, r=g=b = y[CB-1:0] + ofs
  - 2: 8 colour bars, idx = x*8/H_VIS; r = {CB{idx[2]}}, g = {CB{idx[1]}}, b = {CB{idx[0]}}
  - 3: checker, all ones when x[CHK_SHIFT]^y[CHK_SHIFT], else 0
  - 4: split ramps, r = x[CB-1:0], g = y[CB-1:0], b = ofs
  - 5: border, all ones on x==0, x==H_VIS-1, y==0 or y==V_VIS-1; else 0
  - 6: solid white
  - 7: solid grey, MSB only set
- Invert: mode[3] XORs all RGB bits. It applies only when visible.
- Outside the visible region, RGB = 0 regardless of pattern or invert.
- All additions wrap modulo 2^CB with no saturation.
- Reset, with the same priority when asserted mid-frame:
  - h = v = 0, frame = 0, ofs = 0, mode = 0;
  - output regs: rgb = 0, hblank = vblank = visible = 0, hsync = !HSYNC_POL, vsync = !VSYNC_POL, o_hpos = o_vpos = 0, o_mode = 0, o_frame = 0.
  - First cycle after reset deasserts: counters at (0,0). The next cycle shows visible = 1 with pattern 0 pixel 0 (rgb 0).
  - Reset asserted mid-frame restarts at (0,0) on the next edge. No FB update occurs for the aborted frame.
- Simultaneous reset and FB: reset wins.

Test Plan:
- Reset and bring-up, default params: hold reset 3 clks, release -> hsync = vsync = 1. First falling hsync occurs 657 clks after the first visible output (h = 656 + 1 latency) and lasts 96 clks. The hsync period is 800 clks.
- Frame timing: run 2 frames -> vsync low for exactly 1600 clks, starting at line 490. FB every 420000 clks. o_frame goes 0 -> 1 -> 2.
- Colour bars, ui_in = 0x02 applied before the first FB -> in frame 1:
  - x = 79 gives rgb (0,0,0);
  - x = 80 gives (0,0,FF);
  - x = 560 gives (FF,FF,FF);
  - hblank pixels give 0.
- Mode latch timing: change ui_in from 0x00 to 0x06 mid-frame 1 -> o_mode stays 0x00 until FB, then 0x06. Frame 2 visible pixels are all FF; frame 1 remains a ramp.
- Ramp animation and wrap: ui_in = 0x10 (step 1, pattern 0) -> frame k pixel x = 3 gives (3+k) mod 256. o_frame wraps 255 -> 0 after 256 frames.
- Invert and checker, plus mid-frame reset:
  - ui_in = 0x0B -> pixel (0,0) = FF and pixel (16,0) = 00.
  - Asserting reset at h = 300, v = 200 -> outputs take reset values on the following cycle, o_mode = 0, and timing restarts from (0,0).
